// File: rtl/turtle_cpu_pkg.sv
// Shared constants and types for the Turtle CPU program loader.
package turtle_cpu_pkg;

  localparam logic [7:0]  LOADER_SYNC_BYTE      = 8'hA5;
  localparam int unsigned LOADER_BYTES_PER_WORD = 2;

  typedef enum logic [3:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StWrite,
    StCheck,
    StDone,
    StError
  } loader_state_t;

endpackage

// File: rtl/turtle_loader_timeout.sv
// Clearable, enabled, saturating idle counter; expired_o is high once the
// count reaches TIMEOUT_CYCLES.
module turtle_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turtle_program_loader.sv
// Receives framed bytes from the UART, writes 16-bit words into instruction
// memory and holds the CPU in reset until a frame with a good checksum lands.
module turtle_program_loader
  import turtle_cpu_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_WIDTH = 10,
  parameter int unsigned INSTR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [INSTR_WIDTH-1:0]     imem_wdata,
  output logic                       cpu_hold,
  output logic                       load_done,
  output logic                       load_error
);

  // One extra index bit so a frame may fill the whole memory.
  localparam int unsigned IdxW  = IMEM_ADDR_WIDTH + 1;
  localparam int unsigned Depth = 1 << IMEM_ADDR_WIDTH;

  loader_state_t state_q, state_d;
  logic [7:0]    len_hi_q, len_hi_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    chk_q, chk_d;
  logic [IdxW-1:0] n_q, n_d;
  logic [IdxW-1:0] idx_q, idx_d;

  logic                       rx_ready_q, rx_ready_d;
  logic                       imem_we_q, imem_we_d;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [INSTR_WIDTH-1:0]     imem_wdata_q, imem_wdata_d;
  logic                       cpu_hold_q, cpu_hold_d;
  logic                       load_done_q, load_done_d;
  logic                       load_error_q, load_error_d;

  logic        accept;
  logic [15:0] len_w;
  logic        tmo_en, tmo_expired, tmo_fire;

  assign accept = rx_valid && rx_ready_q;
  assign len_w  = {len_hi_q, rx_data};
  assign tmo_en = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StWrite, StCheck};
  // The counter may still read expired for one cycle after leaving the frame.
  assign tmo_fire = tmo_en && tmo_expired;

  turtle_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .clear_i  (accept || !tmo_en),
    .en_i     (tmo_en),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    hi_d         = hi_q;
    chk_d        = chk_q;
    n_d          = n_q;
    idx_d        = idx_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    load_done_d  = load_done_q;
    load_error_d = load_error_q;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (accept && rx_data == LOADER_SYNC_BYTE) begin
          state_d      = StLenHi;
          cpu_hold_d   = 1'b1;
          load_done_d  = 1'b0;
          load_error_d = 1'b0;
          chk_d        = '0;
          idx_d        = '0;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_hi_d = rx_data;
          chk_d    = chk_q ^ rx_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          chk_d = chk_q ^ rx_data;
          n_d   = IdxW'(len_w);
          if (len_w == 16'd0) begin
            state_d = StCheck;
          end else if ({16'd0, len_w} > Depth) begin
            state_d      = StError;
            load_error_d = 1'b1;
          end else begin
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (accept) begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (accept) begin
          chk_d        = chk_q ^ rx_data;
          imem_we_d    = 1'b1;
          imem_addr_d  = idx_q[IMEM_ADDR_WIDTH-1:0];
          imem_wdata_d = {hi_q, rx_data};
          state_d      = StWrite;
        end
      end
      StWrite: begin
        idx_d   = idx_q + IdxW'(1);
        state_d = (idx_d == n_q) ? StCheck : StDataHi;
      end
      StCheck: begin
        if (accept) begin
          if (rx_data == chk_q) begin
            state_d     = StDone;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            state_d      = StError;
            load_error_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (tmo_fire) begin
      state_d      = StError;
      load_error_d = 1'b1;
      imem_we_d    = 1'b0;
    end

    rx_ready_d = (state_d != StWrite);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      len_hi_q     <= '0;
      hi_q         <= '0;
      chk_q        <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      rx_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      hi_q         <= hi_d;
      chk_q        <= chk_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_turtle_program_loader.sv
// Directed bench for turtle_program_loader: table of whole frames plus
// hand-written timeout, mid-frame reset and reload sequences.
module tb_turtle_program_loader;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  turtle_program_loader #(
    .IMEM_ADDR_WIDTH(10),
    .INSTR_WIDTH    (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] bytes;  // right-justified, first byte most significant
    int          n;
    int          nw;
    logic [9:0]  a0;
    logic [15:0] d0;
    logic [9:0]  a1;
    logic [15:0] d1;
    logic        done;
    logic        err;
    logic        hold;
  } vec_t;

  vec_t        tbl [5];
  int          total = 0;
  int          bad = 0;
  logic [9:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  int          rdy_low = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (imem_we) begin
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_wdata);
      end
      if (!rx_ready) rdy_low++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rdy_low = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waits = 0;
    @(negedge clk);
    while (!rx_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL rx_ready_wait: got 0 want 1 for byte %0h", b);
    end else begin
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    logic [9:0]  ea;
    logic [15:0] ed;
    clear_log();
    for (int k = 0; k < v.n; k++) send_byte(v.bytes[8*(v.n-1-k) +: 8]);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_nwrites", id), wr_addr.size(), v.nw);
    for (int j = 0; j < v.nw; j++) begin
      ea = (j == 0) ? v.a0 : v.a1;
      ed = (j == 0) ? v.d0 : v.d1;
      chk($sformatf("v%0d_addr%0d", id, j), (j < wr_addr.size()) ? wr_addr[j] : 'x, ea);
      chk($sformatf("v%0d_data%0d", id, j), (j < wr_data.size()) ? wr_data[j] : 'x, ed);
    end
    chk($sformatf("v%0d_rdy_low", id), rdy_low, v.nw);
    chk($sformatf("v%0d_done", id), load_done, v.done);
    chk($sformatf("v%0d_error", id), load_error, v.err);
    chk($sformatf("v%0d_hold", id), cpu_hold, v.hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{bytes: 96'({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}), n: 8,
               nw: 2, a0: 10'd0, d0: 16'h1234, a1: 10'd1, d1: 16'hABCD,
               done: 1'b1, err: 1'b0, hold: 1'b0};
    tbl[1] = '{bytes: 96'({8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43}), n: 8,
               nw: 2, a0: 10'd0, d0: 16'h1234, a1: 10'd1, d1: 16'hABCD,
               done: 1'b0, err: 1'b1, hold: 1'b1};
    tbl[2] = '{bytes: 96'({8'hA5, 8'h04, 8'h01}), n: 3,
               nw: 0, a0: 10'd0, d0: 16'h0, a1: 10'd0, d1: 16'h0,
               done: 1'b0, err: 1'b1, hold: 1'b1};
    tbl[3] = '{bytes: 96'({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00}), n: 7,
               nw: 0, a0: 10'd0, d0: 16'h0, a1: 10'd0, d1: 16'h0,
               done: 1'b1, err: 1'b0, hold: 1'b0};
    tbl[4] = '{bytes: 96'({8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50}), n: 6,
               nw: 1, a0: 10'd0, d0: 16'hBEEF, a1: 10'd0, d1: 16'h0,
               done: 1'b1, err: 1'b0, hold: 1'b0};

    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, 10'd0);
    chk("rst_wdata", imem_wdata, 16'h0);
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_done", load_done, 1'b0);
    chk("rst_error", load_error, 1'b0);
    chk("rst_ready", rx_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(i, tbl[i]);

    // Reload after a completed zero-length frame, then reset mid-frame.
    clear_log();
    send_byte(8'hA5);
    chk("reload_hold", cpu_hold, 1'b1);
    chk("reload_done", load_done, 1'b0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_we", imem_we, 1'b0);
    chk("midrst_addr", imem_addr, 10'd0);
    chk("midrst_wdata", imem_wdata, 16'h0);
    chk("midrst_hold", cpu_hold, 1'b1);
    chk("midrst_done", load_done, 1'b0);
    chk("midrst_error", load_error, 1'b0);
    chk("midrst_ready", rx_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_nowrite", wr_addr.size(), 0);
    run_vec(4, tbl[4]);

    // Idle timeout inside a frame: error lands 17 edges after the last byte.
    clear_log();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tmo_err_c%0d", c), load_error, (c == 17) ? 1'b1 : 1'b0);
    end
    chk("tmo_hold", cpu_hold, 1'b1);
    chk("tmo_nowrite", wr_addr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turtle_program_loader.md
Name: turtle_program_loader

Overview:
Hardware counterpart of simulation backdoor loading. Receives a framed byte stream from a UART RX (valid/ready), assembles 16-bit instructions, and writes them into the Turtle CPU instruction memory through its write port. Holds the CPU core in reset while a load is in progress and reports done/error. Sits in turtle_cpu_top between the UART receiver and the instruction memory, with cpu_hold ANDed into the core's reset.

Parameters:
IMEM_ADDR_WIDTH, 10, instruction memory address width; depth = 2**IMEM_ADDR_WIDTH words
INSTR_WIDTH, 16, instruction word width; fixed at 2 bytes per word
TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame before abort

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at posedge clk
imem_we  out  1  instruction memory write enable, single-cycle pulse
imem_addr  out  IMEM_ADDR_WIDTH  write address (word index)
imem_wdata  out  INSTR_WIDTH  write data {hi_byte, lo_byte}
cpu_hold  out  1  1 = keep CPU core in reset
load_done  out  1  last frame completed with good checksum
load_error  out  1  last frame aborted (checksum, length, or timeout)

Behaviour:
- Reset: clk and reset_n as above; reset is asynchronous and active-low. All outputs are registered. Reset values: imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0. State=IDLE, so rx_ready=1 after reset.
- Frame format: 0xA5 sync, LEN_HI, LEN_LO (word count N, big-endian), N × {HI, LO}, CHK. CHK = XOR of LEN_HI, LEN_LO and all data bytes. The sync byte is excluded.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR: a byte 0xA5 moves to LEN_HI, sets cpu_hold=1, clears load_done and load_error, and clears the checksum accumulator and word index. Any other byte is consumed and ignored.
- LEN_HI -> LEN_LO -> evaluate N on the cycle after LEN_LO is accepted:
  - N == 0 -> CHECK.
  - N > 2**IMEM_ADDR_WIDTH -> ERROR. No writes occur.
  - Otherwise -> DATA_HI.
- DATA_HI -> DATA_LO. When LO is accepted, go to WRITE.
- WRITE lasts exactly one cycle: imem_we=1, imem_addr=word index, imem_wdata={HI,LO}, rx_ready=0. Then increment the word index. If the index now equals N, go to CHECK; else go to DATA_HI. The index width is IMEM_ADDR_WIDTH+1 so that N = depth is legal.
- rx_ready = 0 only in WRITE; it is 1 in every other state.
- CHECK: the accepted byte is compared with the accumulator. On match, go to DONE; on mismatch, go to ERROR.
- DONE: load_done=1, cpu_hold=0. These are visible the cycle after CHK is accepted.
- ERROR: load_error=1, cpu_hold stays 1. Words already written remain in memory; there is no rollback.
- Timeout: the counter clears on every accepted byte and counts in LEN_HI..CHECK (WRITE included). When the count reaches TIMEOUT_CYCLES, go to ERROR on the next edge.
- Reset mid-frame: all state is dropped immediately and outputs return to reset values. The in-flight word is not written.

Decomposition:
- turtle_cpu_pkg gets:
  - LOADER_SYNC_BYTE (8'hA5)
  - loader_state_t enum
  - LOADER_BYTES_PER_WORD constant
- One sub-module, turtle_loader_timeout, holds the clearable/enabled saturating counter with a `expired` output, parameterised by TIMEOUT_CYCLES.
- The FSM, checksum and address logic stay in turtle_program_loader.

Test Plan:
Use TIMEOUT_CYCLES=16 for all scenarios.
1. Good 2-word load: send bytes A5 00 02 12 34 AB CD 42. Expect exactly two imem_we pulses: addr0=0x1234, then addr1=0xABCD. The cycle after 0x42 is accepted, load_done=1 and cpu_hold=0. rx_ready is low only on the two WRITE cycles.
2. Bad checksum: send the same frame with CHK=0x43. Expect both writes to occur, then load_error=1, load_done=0, cpu_hold=1.
3. Oversize length: send A5 04 01 (N=1025, depth 1024). Expect ERROR the cycle after the length is evaluated, zero imem_we pulses, and load_error=1.
4. Timeout: send A5 00 01 12, then hold rx_valid=0. Expect load_error=1 exactly 17 cycles after the 0x12 acceptance (16 counts + transition), with no write issued.
5. Reset mid-frame: send A5 00 01 12, then pulse reset_n low asynchronously between clock edges. Expect outputs at reset values immediately with no write. A following good frame A5 00 01 BE EF 50 writes 0xBEEF at addr0 and sets load_done.
6. Garbage and reload:
   - Send bytes 00 FF 5A, then A5 00 00 00. The garbage bytes are ignored; the zero-length frame gives load_done=1 with no writes.
   - Then send A5 again. Expect cpu_hold=1 and load_done=0 on the next cycle.
